// File: rtl/mul_output_fifo.sv
// mul_output_fifo: tag realignment and result buffer for the
// pipelined multiplier, with credit-based issue control.
module mul_output_fifo #(
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 2,
  parameter int DEPTH    = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     issue_valid,
  input  logic [TAG_W-1:0]         issue_tag,
  output logic                     issue_ok,
  input  logic                     prod_valid,
  input  logic [DATA_W-1:0]        prod_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_W-1:0]        res_data,
  output logic [TAG_W-1:0]         res_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err,
  output logic                     align_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = $clog2(PIPE_LAT + DEPTH + 1) + 1;

  logic [PIPE_LAT-1:0] dl_v;
  logic [TAG_W-1:0]    dl_tag [PIPE_LAT];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [DATA_W+TAG_W-1:0] mem [DEPTH];

  logic             tail_v;
  logic [TAG_W-1:0] tail_tag;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic             ovf_set;
  logic             align_set;
  logic [SUM_W-1:0] inflight;

  assign tail_v   = dl_v[PIPE_LAT-1];
  assign tail_tag = dl_tag[PIPE_LAT-1];
  assign full     = (count == CNT_W'(DEPTH));
  assign res_valid = (count != '0);
  assign pop      = res_valid && res_ready;
  assign push     = tail_v && prod_valid;
  assign wr_en    = push && (!full || pop);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      inflight = inflight + SUM_W'(dl_v[i]);
    end
  end

  // Credit counts every tag still in the pipe, tail included.
  assign issue_ok =
    (inflight + SUM_W'(count)) < SUM_W'(DEPTH);

  assign ovf_set =
    (push && full && !pop) ||
    (issue_valid && !issue_ok);
  assign align_set = tail_v != prod_valid;

  assign {res_data, res_tag} =
    res_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {prod_data, tail_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      dl_v         <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        dl_tag[i] <= '0;
      end
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
      align_err    <= 1'b0;
    end else begin
      dl_v[0]   <= issue_valid;
      dl_tag[0] <= issue_tag;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dl_v[i]   <= dl_v[i-1];
        dl_tag[i] <= dl_tag[i-1];
      end
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ovf_set)   overflow_err <= 1'b1;
      if (align_set) align_err    <= 1'b1;
    end
  end

endmodule
